wmst_from_out_fm_fifo_tile: RTL
===============================

WMST_FROM_OUT_FM_FIFO_TILE -- requirements
Module: wmst_from_out_fm_fifo_tile

Interface
REQ-001 Parameters (name, default, meaning):
- XAW, 32, Avalon address width
- XDW, 128, Avalon data width
- DW, 32, word width
- CW, 16, counter width
- BLEN, 8, words per burst
- WCNT = XDW/DW, local, words per beat
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock
- rst, in, 1, asynchronous, active-low reset
- store_start, in, 1, one-cycle pulse that latches param_waddr/param_len and begins a tile store
- param_waddr, in, XAW, byte base address, 16-byte aligned
- param_len, in, CW, tile length in words, nonzero multiple of WCNT
- store_done, out, 1, one-cycle pulse when the tile is fully written
- store_fifo_empty, in, 1, output-FIFO empty
- store_fifo_pop, out, 1, output-FIFO pop; data valid next cycle
- store_fifo_data, in, DW, output-FIFO read data
- wmst_fixed_location, out, 1, constant 0
- wmst_write_base, out, XAW, burst byte address
- wmst_write_length, out, XAW, burst byte length
- wmst_go, out, 1, one-cycle burst launch
- wmst_done, in, 1, write master idle/complete level
- wmst_user_write_buffer, out, 1, push one beat
- wmst_user_buffer_data, out, XDW, beat data
- wmst_user_buffer_full, in, 1, write-master FIFO full

Function
REQ-003 FSM states: IDLE, ISSUE, XFER, WAIT, FIN; reset state IDLE.
REQ-004 IDLE: store_start -> latch remaining length rem = param_len and base = param_waddr -> ISSUE; store_start in any other state is ignored.
REQ-005 ISSUE (one cycle):
- wmst_go = 1
- wmst_write_base = base
- wmst_write_length = min(rem, BLEN) << 2
- burst word count bw = min(rem, BLEN)
- next state XFER
REQ-006 XFER: store_fifo_pop = !store_fifo_empty && (popped_in_burst < bw) && (packed + inflight < WCNT || beat being written this cycle).
REQ-007 Packing:
- The popped word, one cycle later, enters the packer at lane packed.
- The first word of each beat occupies bits [DW-1:0]; ascending lanes follow.
- After WCNT words the beat is valid.
REQ-008 Beat write:
- wmst_user_write_buffer = beat_valid && !wmst_user_buffer_full.
- wmst_user_buffer_data holds the beat.
- A beat is consumed only on that cycle.
- While full is asserted, the beat holds stable.
REQ-009 When all bw/WCNT beats of the burst are written:
- rem <= rem - bw
- base <= base + (bw << 2)
- next state WAIT
REQ-010 WAIT: on a wmst_done rising edge (registered compare), go to ISSUE if rem > 0, else FIN; a done level already high on WAIT entry does not count.
REQ-011 FIN: store_done = 1 for exactly one cycle -> IDLE.
REQ-012 No pop occurs outside XFER; words never cross a burst boundary; the last burst may be shorter than BLEN.
REQ-013 Address and length arithmetic is unsigned, width XAW, modulo 2^XAW; wrap-around is not flagged.
REQ-014 Simultaneous beat write and pop in the same cycle are legal; no word is dropped or duplicated.

Reset
REQ-015 While rst = 0, asynchronously:
- FSM -> IDLE
- counters, packer, base, rem -> 0
- wmst_go, wmst_user_write_buffer, store_fifo_pop, store_done -> 0
- wmst_write_base, wmst_write_length, wmst_user_buffer_data -> 0
- wmst_fixed_location = 0 always
REQ-016 Reset mid-transfer discards partial beats and remaining length; no store_done is produced.

Verification
REQ-017 param_waddr=0x1000, param_len=8, FIFO words 1..8, full=0:
- one go, base 0x1000, length 32
- beats {4,3,2,1} then {8,7,6,5} (MSW..LSW)
- done pulse 1 -> store_done once
REQ-018 param_len=20, BLEN=8, go timing:
- three go pulses with lengths 32, 32, 16 and bases 0x1000, 0x1020, 0x1040
- each go follows a done rising edge
REQ-019 wmst_user_buffer_full held high 5 cycles mid-burst:
- beat data held stable
- pops stall after the packer fills
- no word lost
REQ-020 store_fifo_empty toggling every other cycle: output beats identical to REQ-017.
REQ-021 rst asserted during the second beat, then released and param_len=4 started:
- outputs zero during reset
- new store produces exactly one beat and one store_done
REQ-022 wmst_done held high through WAIT entry: no next go until done falls and rises again.

Source files
------------

// File: rtl/wmst_from_out_fm_fifo_tile_if.sv
// Bundle of the tile-store control, output-FIFO read port and write-master port.
// The master modport is the tile store engine; slave is its environment.
interface wmst_from_out_fm_fifo_tile_if #(
  parameter int XAW = 32,
  parameter int XDW = 128,
  parameter int DW  = 32,
  parameter int CW  = 16
);
  logic           store_start;
  logic [XAW-1:0] param_waddr;
  logic [CW-1:0]  param_len;
  logic           store_done;

  logic           store_fifo_empty;
  logic           store_fifo_pop;
  logic [DW-1:0]  store_fifo_data;

  logic           wmst_fixed_location;
  logic [XAW-1:0] wmst_write_base;
  logic [XAW-1:0] wmst_write_length;
  logic           wmst_go;
  logic           wmst_done;
  logic           wmst_user_write_buffer;
  logic [XDW-1:0] wmst_user_buffer_data;
  logic           wmst_user_buffer_full;

  modport master (
    input  store_start, param_waddr, param_len,
    input  store_fifo_empty, store_fifo_data,
    input  wmst_done, wmst_user_buffer_full,
    output store_done, store_fifo_pop,
    output wmst_fixed_location, wmst_write_base, wmst_write_length, wmst_go,
    output wmst_user_write_buffer, wmst_user_buffer_data
  );

  modport slave (
    output store_start, param_waddr, param_len,
    output store_fifo_empty, store_fifo_data,
    output wmst_done, wmst_user_buffer_full,
    input  store_done, store_fifo_pop,
    input  wmst_fixed_location, wmst_write_base, wmst_write_length, wmst_go,
    input  wmst_user_write_buffer, wmst_user_buffer_data
  );
endinterface

// File: rtl/wmst_from_out_fm_fifo_tile.sv
// Drains a tile of words from the output FIFO, packs them into wide beats and
// writes them out as a sequence of write-master bursts of at most BLEN words.
module wmst_from_out_fm_fifo_tile #(
  parameter int XAW  = 32,
  parameter int XDW  = 128,
  parameter int DW   = 32,
  parameter int CW   = 16,
  parameter int BLEN = 8
) (
  input logic clk,
  input logic rst,
  wmst_from_out_fm_fifo_tile_if.master bus
);
  localparam int WCNT = XDW / DW;
  localparam int PW   = $clog2(WCNT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, XFER, WAIT, FIN} state_t;

  state_t                  state, nxt;
  logic [CW-1:0]           rem, bw, popped, beats, burst_words;
  logic [XAW-1:0]          base;
  logic [PW-1:0]           fill, lane_base;
  logic                    inflight, done_q;
  logic                    beat_valid, wr, last_beat, room, pop;
  logic [WCNT-1:0][DW-1:0] lanes;

  always_comb begin
    burst_words = (rem < CW'(BLEN)) ? rem : CW'(BLEN);
    beat_valid  = (fill == PW'(WCNT));
    wr          = (state == XFER) && beat_valid && !bus.wmst_user_buffer_full;
    last_beat   = wr && (beats == (bw / CW'(WCNT)) - CW'(1));
    // The word popped last cycle still needs a lane, so count it as occupied.
    room        = (int'(fill) + int'(inflight)) < WCNT;
    pop         = (state == XFER) && !bus.store_fifo_empty && (popped < bw) && (room || wr);
    lane_base   = wr ? '0 : fill;
    nxt         = state;
    case (state)
      IDLE:    if (bus.store_start) nxt = ISSUE;
      ISSUE:   nxt = XFER;
      XFER:    if (last_beat) nxt = WAIT;
      WAIT:    if (bus.wmst_done && !done_q) nxt = (rem != '0) ? ISSUE : FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rem      <= '0;
      bw       <= '0;
      popped   <= '0;
      beats    <= '0;
      base     <= '0;
      fill     <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      lanes    <= '0;
    end else begin
      state    <= nxt;
      done_q   <= bus.wmst_done;
      inflight <= pop;
      // A beat leaving this cycle frees the packer, so the arriving word lands in lane 0.
      fill     <= lane_base + PW'(inflight);
      for (int i = 0; i < WCNT; i++)
        if (inflight && lane_base == PW'(i)) lanes[i] <= bus.store_fifo_data;
      case (state)
        IDLE: if (bus.store_start) begin
          rem  <= bus.param_len;
          base <= bus.param_waddr;
        end
        ISSUE: begin
          bw     <= burst_words;
          popped <= '0;
          beats  <= '0;
        end
        XFER: begin
          if (pop) popped <= popped + CW'(1);
          if (wr)  beats  <= beats + CW'(1);
          if (last_beat) begin
            rem  <= rem - bw;
            base <= base + (XAW'(bw) << 2);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.store_fifo_pop         = pop;
  assign bus.store_done             = (state == FIN);
  assign bus.wmst_fixed_location    = 1'b0;
  assign bus.wmst_go                = (state == ISSUE);
  assign bus.wmst_write_base        = base;
  assign bus.wmst_write_length      = XAW'(burst_words) << 2;
  assign bus.wmst_user_write_buffer = wr;
  assign bus.wmst_user_buffer_data  = lanes;
endmodule
